inst_fetch_ctrl: RTL and testbench



---
 rtl/inst_fetch_ctrl_pkg.sv | 16 +
 rtl/inst_fetch_ctrl_fetch_queue.sv | 54 +++++
 rtl/inst_fetch_ctrl.sv | 106 ++++++++++
 tb/tb_inst_fetch_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared fetch definitions: control state encoding, instruction size
// and default widths, for the fetch unit and the core control unit.
package inst_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } ifetch_state_e;

    localparam int INST_BYTES     = 4;
    localparam int IFETCH_ADDR_W  = 12;
    localparam int IFETCH_INST_W  = 32;

endpackage

// File: rtl/inst_fetch_ctrl_fetch_queue.sv
// fetch_queue: synchronous FIFO with flush and head/count outputs.
// Ports: clk, rst_n, push_i, pop_i, flush_i, din_i, head_o, count_o.
module fetch_queue #(
    parameter int W     = 44,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] P1   = PW'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [PW:0]   cnt_q;
    logic          do_pop, do_push;

    // Pop on empty is dropped; a push into a full queue needs a pop
    // in the same cycle to make room.
    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != FULL) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + P1;
            end
            if (do_pop) rd_q <= rd_q + P1;
            cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the instruction
// memory address and queues {Inst, pc} for decode (valid/ready).
// Ports: start/halt_req/branch_* control in, readAddr/Inst memory side,
// inst_valid/inst_ready/inst_out/inst_pc decode side, busy/fault status.
// Optional macro IFETCH_ALIGN_CHECK_EN: misaligned redirect -> FAULT.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int              ADDR_W   = IFETCH_ADDR_W,
    parameter int              INST_W   = IFETCH_INST_W,
    parameter int              QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_req,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] readAddr,
    input  logic [INST_W-1:0] Inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              busy,
    output logic              fault
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_HALT  = HALT;
`ifdef IFETCH_ALIGN_CHECK_EN
    localparam logic [1:0] S_FAULT = FAULT;
`endif

    logic [1:0]               state_q, state_d;
    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic [CW-1:0]            count;
    logic [INST_W+ADDR_W-1:0] head;
    logic                     pop, push, misalign;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign misalign = branch_valid && (branch_target[1:0] != 2'b00);
    assign fault    = (state_q == S_FAULT);
`else
    assign misalign = 1'b0;
    assign fault    = 1'b0;
`endif

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign push       = (state_q == S_RUN) && !branch_valid && !halt_req
                        && ((count != QFULL) || pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (branch_valid) begin
            // Redirect wins in any state and never changes the state,
            // except that a misaligned target traps.
            if (misalign) state_d = 2'(FAULT);
            else          pc_d    = branch_target;
        end else begin
            if (push) pc_d = pc_q + ADDR_W'(INST_BYTES);
            unique case (state_q)
                S_IDLE, S_HALT: if (start && !halt_req) state_d = S_RUN;
                S_RUN:          if (halt_req) state_d = S_HALT;
                default:        ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_queue #(
        .W     (INST_W + ADDR_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (branch_valid),
        .din_i   ({Inst, pc_q}),
        .head_o  (head),
        .count_o (count)
    );

    assign readAddr = pc_q;
    assign inst_out = head[INST_W+ADDR_W-1:ADDR_W];
    assign inst_pc  = head[ADDR_W-1:0];
    assign busy     = (state_q == S_RUN);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a small combinational
// instruction memory model.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, halt_req, branch_valid, inst_ready;
    logic [11:0] branch_target, readAddr, inst_pc;
    logic [31:0] Inst, inst_out;
    logic        inst_valid, busy, fault;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        unique case (readAddr)
            12'h000: Inst = 32'd3;
            12'h004: Inst = 32'd6;
            12'h008: Inst = 32'd16;
            12'h00C: Inst = 32'd32;
            12'h010: Inst = 32'd64;
            12'hFFC: Inst = 32'hCAFE_0FFC;
            default: Inst = 32'h0000_0013;
        endcase
    end

    inst_fetch_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .halt_req      (halt_req),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .readAddr      (readAddr),
        .Inst          (Inst),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .busy          (busy),
        .fault         (fault)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input logic [31:0] ei,
                        input logic [11:0] ep);
        chk({tag, ".valid"}, 64'(inst_valid), 64'd1);
        chk({tag, ".inst"}, 64'(inst_out), 64'(ei));
        chk({tag, ".pc"}, 64'(inst_pc), 64'(ep));
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("rst.valid", 64'(inst_valid), 64'd0);
        chk("rst.addr", 64'(readAddr), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.fault", 64'(fault), 64'd0);
        #2 rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic redirect(input logic [11:0] t);
        branch_valid  = 1'b1;
        branch_target = t;
        step();
        branch_valid  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
        branch_valid = 1'b0; branch_target = '0; inst_ready = 1'b0;
        #2;
        chk("rst0.valid", 64'(inst_valid), 64'd0);
        chk("rst0.inst", 64'(inst_out), 64'd0);
        chk("rst0.pc", 64'(inst_pc), 64'd0);
        chk("rst0.busy", 64'(busy), 64'd0);
        chk("rst0.fault", 64'(fault), 64'd0);
        chk("rst0.addr", 64'(readAddr), 64'd0);
        #10 rst_n = 1'b1;

        // 1: streaming with decode always ready
        step();
        inst_ready = 1'b1;
        pulse_start();
        chk("t1.busy", 64'(busy), 64'd1);
        chk("t1.first_valid", 64'(inst_valid), 64'd0);
        step(); head("t1.h0", 32'd3, 12'h000);
        step(); head("t1.h1", 32'd6, 12'h004);
        step(); head("t1.h2", 32'd16, 12'h008);
        step(); head("t1.h3", 32'd32, 12'h00C);
        step(); head("t1.h4", 32'd64, 12'h010);

        // 2: backpressure fills the queue, then push+pop at full
        do_reset();
        inst_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 5; i++) step();
        head("t2.hold", 32'd3, 12'h000);
        chk("t2.addr", 64'(readAddr), 64'h008);
        inst_ready = 1'b1;
        step(); head("t2.h1", 32'd6, 12'h004);
        chk("t2.addr1", 64'(readAddr), 64'h00C);
        step(); head("t2.h2", 32'd16, 12'h008);
        chk("t2.addr2", 64'(readAddr), 64'h010);

        // 3: redirect while running
        redirect(12'h00C);
        chk("t3.flush", 64'(inst_valid), 64'd0);
        chk("t3.addr", 64'(readAddr), 64'h00C);
        step(); head("t3.h0", 32'd32, 12'h00C);
        step(); head("t3.h1", 32'd64, 12'h010);

        // 4: halt after two fetches, drain, resume at held pc
        inst_ready = 1'b0;
        redirect(12'h000);
        step(); step();
        head("t4.full", 32'd3, 12'h000);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        chk("t4.busy", 64'(busy), 64'd0);
        chk("t4.addr", 64'(readAddr), 64'h008);
        inst_ready = 1'b1;
        step(); head("t4.d1", 32'd6, 12'h004);
        step();
        chk("t4.empty", 64'(inst_valid), 64'd0);
        step();
        chk("t4.addr_hold", 64'(readAddr), 64'h008);
        chk("t4.still_empty", 64'(inst_valid), 64'd0);
        pulse_start();
        chk("t4.resume", 64'(busy), 64'd1);
        step(); head("t4.r0", 32'd16, 12'h008);

        // 5: pc wrap at the top of the address space
        redirect(12'hFFC);
        chk("t5.addr", 64'(readAddr), 64'hFFC);
        step(); head("t5.h", 32'hCAFE_0FFC, 12'hFFC);
        chk("t5.wrap", 64'(readAddr), 64'h000);
        chk("t5.fault", 64'(fault), 64'd0);
        step(); head("t5.h1", 32'd3, 12'h000);

        // redirect in IDLE only moves the pc
        do_reset();
        redirect(12'h010);
        chk("idle.addr", 64'(readAddr), 64'h010);
        chk("idle.busy", 64'(busy), 64'd0);
        step();
        chk("idle.nofetch", 64'(inst_valid), 64'd0);
        chk("idle.addr2", 64'(readAddr), 64'h010);

`ifdef IFETCH_ALIGN_CHECK_EN
        // 6: misaligned redirect traps
        pulse_start();
        redirect(12'h006);
        chk("t6.fault", 64'(fault), 64'd1);
        chk("t6.busy", 64'(busy), 64'd0);
        chk("t6.valid", 64'(inst_valid), 64'd0);
        pulse_start();
        chk("t6.sticky", 64'(fault), 64'd1);
        chk("t6.nostart", 64'(busy), 64'd0);
        do_reset();
        chk("t6.clear", 64'(fault), 64'd0);
`else
        redirect(12'h006);
        chk("t6.addr", 64'(readAddr), 64'h006);
        chk("t6.nofault", 64'(fault), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
